frame_slot_mux: RTL and testbench
=================================

FRAME_SLOT_MUX -- requirements
Module: frame_slot_mux

Interface
REQ-001 The block SHALL have parameter NUM_CH, default 4, meaning the number of drawing channels (legal range 2..8).
REQ-002 The block SHALL have parameter RGB_W, default 8, meaning the per-channel colour width.
REQ-003 The block SHALL have parameter EDGE_W, default 4, meaning the per-channel hit-edge code width (one bit per edge).
REQ-004 The block SHALL have parameter SLOT_FRAMES, default 1, meaning frames per channel slot in rotate mode (legal range 1..255).
REQ-005 clk  in  1  system clock; every register SHALL update on its rising edge.
REQ-006 reset  in  1  asynchronous, active-high reset.
REQ-007 startOfFrame  in  1  frame-start strobe; may stay high for more than one cycle.
REQ-008 mode  in  1  selection mode: 0 = rotate (time-slot), 1 = priority.
REQ-009 enableMask  in  NUM_CH  per-channel enable.
REQ-010 DrawingRequest_in  in  NUM_CH  per-channel draw request; bit i = channel i.
REQ-011 RGB_in  in  NUM_CH*RGB_W  packed colours; channel i occupies bits [i*RGB_W +: RGB_W].
REQ-012 HitEdgeCode_in  in  NUM_CH*EDGE_W  packed edge codes, packed the same way as RGB_in.
REQ-013 drawingRequest_out  out  1  registered selected request.
REQ-014 RGBout  out  RGB_W  registered selected colour.
REQ-015 HitEdgeCode  out  EDGE_W  registered selected edge code.
REQ-016 activeChannel  out  clog2(NUM_CH)  current rotate-mode slot index.
REQ-017 slotValid  out  1  high when the latched mask has at least one enabled channel.

Function
REQ-018 A frame event SHALL occur in any cycle where startOfFrame=1 and the previous-cycle sample of startOfFrame=0 (rising edge); a held-high strobe SHALL yield exactly one event.
REQ-019 On each frame event the block SHALL latch enableMask into maskReg; mask changes between events SHALL have no effect.
REQ-020 Frame counter frameCnt (8 bit) SHALL increment on each frame event.
- When frameCnt reaches SLOT_FRAMES-1 at an event, the counter SHALL clear and the slot SHALL advance.
REQ-021 Slot advance SHALL move activeChannel to the next higher index enabled in the newly latched maskReg, wrapping from NUM_CH-1 to 0 and skipping disabled channels.
REQ-022 If the current channel is the only enabled channel, advance SHALL leave activeChannel unchanged.
REQ-023 If the current channel becomes disabled in the newly latched maskReg, the slot SHALL advance on that event regardless of frameCnt, and frameCnt SHALL clear.
REQ-024 If maskReg is all zeros, slotValid SHALL be 0 and activeChannel and frameCnt SHALL hold their values.
REQ-025 Rotate mode: the selected channel SHALL be activeChannel, with its request gated by maskReg.
REQ-026 Priority mode: the selected channel SHALL be the lowest index i with maskReg[i]=1 and DrawingRequest_in[i]=1.
- With no such channel, drawingRequest_out SHALL be 0.
- activeChannel SHALL keep rotating as in REQ-020..REQ-023.
REQ-027 Outputs SHALL be registered with exactly 1 clk latency from the inputs.
REQ-028 When the selected request is 0 or slotValid=0, drawingRequest_out, RGBout and HitEdgeCode SHALL all register 0.
REQ-029 A mode change SHALL take effect on the next clk edge and SHALL NOT disturb frameCnt or activeChannel.
REQ-030 A frame event and a selection SHALL be able to occur in the same cycle; that cycle's output SHALL use the pre-event maskReg and activeChannel.

Reset
REQ-031 While reset=1, all outputs SHALL be 0, and activeChannel, frameCnt and the startOfFrame sample SHALL be 0.
REQ-032 While reset=1, maskReg SHALL be all ones, so slotValid=1 after reset until the first frame event.
REQ-033 Reset asserted mid-slot SHALL abort immediately (asynchronously); after release, operation SHALL resume from channel 0 with frameCnt=0.

Verification
REQ-034 Rotate wrap: NUM_CH=4, SLOT_FRAMES=1, mask=1111, all requests 1, RGB_in i=8'h10+i, 5 events -> activeChannel 1,2,3,0,1 and RGBout 11,12,13,10,11 one clk after each event.
REQ-035 Skip and dwell: mask=0101, SLOT_FRAMES=2, 6 events -> activeChannel steps 0,2,2,0,0,2 (changes every second event).
REQ-036 Priority: mode=1, mask=1111, requests=1100 -> drawingRequest_out=1 with RGB of channel 2; requests=0000 -> all outputs 0 next clk.
REQ-037 Empty mask: enableMask=0000 at an event -> slotValid=0, outputs 0, activeChannel held; mask=0010 at the next event -> activeChannel=1, slotValid=1.
REQ-038 Held strobe and reset: startOfFrame high for 5 cycles -> frameCnt advances once; assert reset mid-slot -> outputs 0 in the same cycle, activeChannel=0 after release.

Source files
------------

// File: rtl/frame_slot_mux_if.sv
// frame_slot_mux_if -- bundle of the per-channel drawing inputs and the
// selected outputs of frame_slot_mux.
//   master : drives startOfFrame, mode, enableMask, DrawingRequest_in,
//            RGB_in, HitEdgeCode_in; observes the selected outputs.
//   slave  : the mux itself; drives drawingRequest_out, RGBout,
//            HitEdgeCode, activeChannel, slotValid.
interface frame_slot_mux_if #(
  parameter int NUM_CH = 4,
  parameter int RGB_W  = 8,
  parameter int EDGE_W = 4
);
  localparam int CH_W = $clog2(NUM_CH);

  logic                     startOfFrame;
  logic                     mode;
  logic [NUM_CH-1:0]        enableMask;
  logic [NUM_CH-1:0]        DrawingRequest_in;
  logic [NUM_CH*RGB_W-1:0]  RGB_in;
  logic [NUM_CH*EDGE_W-1:0] HitEdgeCode_in;
  logic                     drawingRequest_out;
  logic [RGB_W-1:0]         RGBout;
  logic [EDGE_W-1:0]        HitEdgeCode;
  logic [CH_W-1:0]          activeChannel;
  logic                     slotValid;

  modport master (
    output startOfFrame, mode, enableMask, DrawingRequest_in, RGB_in, HitEdgeCode_in,
    input  drawingRequest_out, RGBout, HitEdgeCode, activeChannel, slotValid
  );

  modport slave (
    input  startOfFrame, mode, enableMask, DrawingRequest_in, RGB_in, HitEdgeCode_in,
    output drawingRequest_out, RGBout, HitEdgeCode, activeChannel, slotValid
  );
endinterface

// File: rtl/frame_slot_mux.sv
// frame_slot_mux -- selects one of NUM_CH drawing channels per clock and
// registers its request, colour and hit-edge code.
//   clk   : system clock, rising edge
//   reset : asynchronous, active-high
//   bus   : frame_slot_mux_if.slave (strobe, mode, mask, per-channel
//           requests/colours/edge codes in; selected outputs, slot index
//           and slot-valid flag out)
// Rotate mode gives each enabled channel SLOT_FRAMES frames in turn;
// priority mode picks the lowest enabled requesting channel.
module frame_slot_mux #(
  parameter int NUM_CH      = 4,
  parameter int RGB_W       = 8,
  parameter int EDGE_W      = 4,
  parameter int SLOT_FRAMES = 1
) (
  input  logic              clk,
  input  logic              reset,
  frame_slot_mux_if.slave   bus
);
  localparam int CH_W = $clog2(NUM_CH);
  localparam logic [CH_W:0] NUM_CH_V   = (CH_W+1)'(NUM_CH);
  localparam logic [7:0]    LAST_FRAME = 8'(SLOT_FRAMES - 1);

  logic                sof_prev_reg;
  logic [NUM_CH-1:0]   mask_reg;
  logic [7:0]          frame_cnt_reg;
  logic [CH_W-1:0]     active_reg;
  logic                req_reg;
  logic [RGB_W-1:0]    rgb_reg;
  logic [EDGE_W-1:0]   edge_reg;
  logic                valid_reg;

  logic [RGB_W-1:0]    rgb_arr  [NUM_CH];
  logic [EDGE_W-1:0]   edge_arr [NUM_CH];

  logic                frame_event;
  logic [CH_W-1:0]     next_ch;
  logic [CH_W-1:0]     pri_ch;
  logic                pri_hit;
  logic                rot_hit;
  logic [CH_W-1:0]     sel_ch;
  logic                sel_take;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_CH; gi++) begin : g_unpack
      assign rgb_arr[gi]  = bus.RGB_in[gi*RGB_W +: RGB_W];
      assign edge_arr[gi] = bus.HitEdgeCode_in[gi*EDGE_W +: EDGE_W];
    end
  endgenerate

  // Rising edge of the strobe only; a held strobe counts once.
  assign frame_event = bus.startOfFrame & ~sof_prev_reg;

  // Next enabled channel above the current one in the incoming mask,
  // wrapping; stays put if no other channel is enabled.
  always_comb begin
    logic [CH_W:0] idx;
    logic          found;
    next_ch = active_reg;
    found   = 1'b0;
    idx     = '0;
    for (int k = 1; k < NUM_CH; k++) begin
      idx = {1'b0, active_reg} + (CH_W+1)'(k);
      if (idx >= NUM_CH_V) idx = idx - NUM_CH_V;
      if (!found && bus.enableMask[idx[CH_W-1:0]]) begin
        found   = 1'b1;
        next_ch = idx[CH_W-1:0];
      end
    end
  end

  // Lowest-index enabled requester (scan downward so the lowest wins).
  always_comb begin
    pri_ch  = '0;
    pri_hit = 1'b0;
    for (int i = NUM_CH - 1; i >= 0; i--) begin
      if (mask_reg[i] && bus.DrawingRequest_in[i]) begin
        pri_hit = 1'b1;
        pri_ch  = CH_W'(i);
      end
    end
  end

  // Selection always uses the pre-event mask and slot.
  assign rot_hit  = mask_reg[active_reg] & bus.DrawingRequest_in[active_reg];
  assign sel_ch   = bus.mode ? pri_ch : active_reg;
  assign sel_take = (bus.mode ? pri_hit : rot_hit) & (|mask_reg);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sof_prev_reg  <= 1'b0;
      mask_reg      <= '1;
      frame_cnt_reg <= '0;
      active_reg    <= '0;
      req_reg       <= 1'b0;
      rgb_reg       <= '0;
      edge_reg      <= '0;
      valid_reg     <= 1'b0;
    end else begin
      sof_prev_reg <= bus.startOfFrame;
      req_reg      <= sel_take;
      rgb_reg      <= sel_take ? rgb_arr[sel_ch]  : '0;
      edge_reg     <= sel_take ? edge_arr[sel_ch] : '0;
      // Registered view of "latched mask has an enabled channel".
      valid_reg    <= frame_event ? (|bus.enableMask) : (|mask_reg);

      if (frame_event) begin
        mask_reg <= bus.enableMask;
        // An all-zero mask freezes both the slot and the frame count.
        if (|bus.enableMask) begin
          if (!bus.enableMask[active_reg] || frame_cnt_reg == LAST_FRAME) begin
            active_reg    <= next_ch;
            frame_cnt_reg <= '0;
          end else begin
            frame_cnt_reg <= frame_cnt_reg + 8'd1;
          end
        end
      end
    end
  end

  assign bus.drawingRequest_out = req_reg;
  assign bus.RGBout             = rgb_reg;
  assign bus.HitEdgeCode        = edge_reg;
  assign bus.activeChannel      = active_reg;
  assign bus.slotValid          = valid_reg;
endmodule

// File: tb/tb_frame_slot_mux.sv
// tb_frame_slot_mux -- directed bench for frame_slot_mux. Two instances
// share the same stimulus: dut_a with SLOT_FRAMES=1, dut_b with
// SLOT_FRAMES=2. A behavioural model predicts both every clock and is
// compared on each falling edge; literal checks pin the documented cases.
module tb_frame_slot_mux;
  logic clk;
  logic reset;

  frame_slot_mux_if #(.NUM_CH(4), .RGB_W(8), .EDGE_W(4)) if_a ();
  frame_slot_mux_if #(.NUM_CH(4), .RGB_W(8), .EDGE_W(4)) if_b ();

  frame_slot_mux #(.NUM_CH(4), .RGB_W(8), .EDGE_W(4), .SLOT_FRAMES(1)) dut_a (
    .clk(clk), .reset(reset), .bus(if_a.slave));
  frame_slot_mux #(.NUM_CH(4), .RGB_W(8), .EDGE_W(4), .SLOT_FRAMES(2)) dut_b (
    .clk(clk), .reset(reset), .bus(if_b.slave));

  assign if_b.startOfFrame      = if_a.startOfFrame;
  assign if_b.mode              = if_a.mode;
  assign if_b.enableMask        = if_a.enableMask;
  assign if_b.DrawingRequest_in = if_a.DrawingRequest_in;
  assign if_b.RGB_in            = if_a.RGB_in;
  assign if_b.HitEdgeCode_in    = if_a.HitEdgeCode_in;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int n_event = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  int         sfr [2] = '{1, 2};
  logic [3:0] m_mask [2];
  int         m_act [2];
  int         m_cnt [2];
  logic       m_prev;
  logic       e_req [2];
  logic [7:0] e_rgb [2];
  logic [3:0] e_edge [2];
  int         e_act [2];
  logic       e_valid [2];

  // Smallest enabled index above cur; otherwise wrap to the smallest
  // enabled index overall (which may be cur itself).
  function automatic int next_enabled(input logic [3:0] m, input int cur);
    int r = -1;
    for (int i = cur + 1; i < 4; i++) if (r < 0 && m[i]) r = i;
    for (int i = 0; i <= cur; i++)    if (r < 0 && m[i]) r = i;
    return r;
  endfunction

  task automatic model_reset();
    for (int d = 0; d < 2; d++) begin
      m_mask[d] = 4'hF; m_act[d] = 0; m_cnt[d] = 0;
      e_req[d] = 0; e_rgb[d] = 0; e_edge[d] = 0; e_act[d] = 0; e_valid[d] = 0;
    end
    m_prev = 0;
  endtask

  task automatic model_step(input int d, input logic ev);
    int ch = -1;
    logic [31:0] rv = if_a.RGB_in;
    logic [15:0] hv = if_a.HitEdgeCode_in;
    logic [3:0]  rq = if_a.DrawingRequest_in;
    logic [3:0]  nm = if_a.enableMask;
    if (if_a.mode) begin
      for (int i = 0; i < 4; i++) if (ch < 0 && m_mask[d][i] && rq[i]) ch = i;
    end else if (m_mask[d][m_act[d]] && rq[m_act[d]]) begin
      ch = m_act[d];
    end
    if (ch >= 0) begin
      e_req[d] = 1; e_rgb[d] = rv[ch*8 +: 8]; e_edge[d] = hv[ch*4 +: 4];
    end else begin
      e_req[d] = 0; e_rgb[d] = 0; e_edge[d] = 0;
    end
    if (ev) begin
      m_mask[d] = nm;
      if (nm != 0) begin
        m_cnt[d]++;
        if (!nm[m_act[d]] || m_cnt[d] == sfr[d]) begin
          m_act[d] = next_enabled(nm, m_act[d]);
          m_cnt[d] = 0;
        end
      end
    end
    e_act[d]   = m_act[d];
    e_valid[d] = (m_mask[d] != 0);
  endtask

  initial begin
    model_reset();
    forever begin
      @(posedge clk or posedge reset);
      if (reset) model_reset();
      else begin
        logic ev;
        ev = if_a.startOfFrame && !m_prev;
        model_step(0, ev);
        model_step(1, ev);
        m_prev = if_a.startOfFrame;
      end
    end
  end

  // Per-cycle comparison against the model.
  initial begin
    forever begin
      @(negedge clk);
      chk("a.req",   32'(if_a.drawingRequest_out), 32'(e_req[0]));
      chk("a.rgb",   32'(if_a.RGBout),             32'(e_rgb[0]));
      chk("a.edge",  32'(if_a.HitEdgeCode),        32'(e_edge[0]));
      chk("a.ch",    32'(if_a.activeChannel),      32'(e_act[0]));
      chk("a.valid", 32'(if_a.slotValid),          32'(e_valid[0]));
      chk("b.req",   32'(if_b.drawingRequest_out), 32'(e_req[1]));
      chk("b.rgb",   32'(if_b.RGBout),             32'(e_rgb[1]));
      chk("b.edge",  32'(if_b.HitEdgeCode),        32'(e_edge[1]));
      chk("b.ch",    32'(if_b.activeChannel),      32'(e_act[1]));
      chk("b.valid", 32'(if_b.slotValid),          32'(e_valid[1]));
    end
  end

  // ---------------- stimulus ----------------
  // Entered and left at posedge+1; one line per frame event.
  task automatic frame_event();
    if_a.startOfFrame = 1'b1;
    @(posedge clk); #1;
    if_a.startOfFrame = 1'b0;
    @(posedge clk); #1;
    n_event++;
    $display("event %0d: a.ch=%0d a.rgb=%h b.ch=%0d b.rgb=%h valid=%b/%b", n_event,
             if_a.activeChannel, if_a.RGBout, if_b.activeChannel, if_b.RGBout,
             if_a.slotValid, if_b.slotValid);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    @(posedge clk); #1;
  endtask

  logic [7:0] exp_rgb34 [5] = '{8'h11, 8'h12, 8'h13, 8'h10, 8'h11};
  int         exp_ch34  [5] = '{1, 2, 3, 0, 1};
  int         exp_ch35  [6] = '{0, 2, 2, 0, 0, 2};
  logic [3:0] mix_mask  [8] = '{4'hF, 4'h5, 4'hA, 4'h8, 4'h0, 4'h3, 4'h6, 4'hF};

  initial begin
    reset = 1'b1;
    if_a.startOfFrame      = 1'b0;
    if_a.mode              = 1'b0;
    if_a.enableMask        = 4'hF;
    if_a.DrawingRequest_in = 4'hF;
    if_a.RGB_in            = {8'h13, 8'h12, 8'h11, 8'h10};
    if_a.HitEdgeCode_in    = {4'h8, 4'h4, 4'h2, 4'h1};
    repeat (2) @(posedge clk);
    #1;
    chk("rst.req",   32'(if_a.drawingRequest_out), 32'd0);
    chk("rst.rgb",   32'(if_a.RGBout),             32'd0);
    chk("rst.ch",    32'(if_a.activeChannel),      32'd0);
    reset = 1'b0;
    @(posedge clk); #1;
    chk("post_rst.valid", 32'(if_a.slotValid), 32'd1);
    chk("post_rst.rgb",   32'(if_a.RGBout),    32'h10);

    // Rotate wrap, one frame per slot.
    for (int k = 0; k < 5; k++) begin
      frame_event();
      chk("wrap.ch",  32'(if_a.activeChannel), 32'(exp_ch34[k]));
      chk("wrap.rgb", 32'(if_a.RGBout),        32'(exp_rgb34[k]));
    end

    // Skip disabled channels and dwell two frames per slot.
    if_a.enableMask = 4'b0101;
    do_reset();
    for (int k = 0; k < 6; k++) begin
      frame_event();
      chk("dwell.ch", 32'(if_b.activeChannel), 32'(exp_ch35[k]));
    end

    // Priority mode.
    if_a.enableMask = 4'hF;
    frame_event();
    if_a.mode = 1'b1;
    if_a.DrawingRequest_in = 4'b1100;
    @(posedge clk); #1;
    chk("pri.req",  32'(if_a.drawingRequest_out), 32'd1);
    chk("pri.rgb",  32'(if_a.RGBout),             32'h12);
    chk("pri.edge", 32'(if_a.HitEdgeCode),        32'h4);
    if_a.DrawingRequest_in = 4'b0000;
    @(posedge clk); #1;
    chk("pri0.req",  32'(if_a.drawingRequest_out), 32'd0);
    chk("pri0.rgb",  32'(if_a.RGBout),             32'd0);
    chk("pri0.edge", 32'(if_a.HitEdgeCode),        32'd0);

    // Empty mask freezes the slot; then a single-channel mask.
    if_a.mode = 1'b0;
    if_a.DrawingRequest_in = 4'hF;
    if_a.enableMask = 4'b0000;
    frame_event();
    chk("empty.valid", 32'(if_a.slotValid),          32'd0);
    chk("empty.req",   32'(if_a.drawingRequest_out), 32'd0);
    chk("empty.rgb",   32'(if_a.RGBout),             32'd0);
    chk("empty.ch_a",  32'(if_a.activeChannel),      32'd1);
    chk("empty.ch_b",  32'(if_b.activeChannel),      32'd2);
    if_a.enableMask = 4'b0010;
    frame_event();
    chk("one.ch_a",  32'(if_a.activeChannel), 32'd1);
    chk("one.ch_b",  32'(if_b.activeChannel), 32'd1);
    chk("one.valid", 32'(if_b.slotValid),     32'd1);

    // Held strobe yields exactly one event.
    if_a.enableMask = 4'hF;
    frame_event();
    if_a.startOfFrame = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    if_a.startOfFrame = 1'b0;
    @(posedge clk); #1;
    chk("held.ch_a", 32'(if_a.activeChannel), 32'd3);
    chk("held.ch_b", 32'(if_b.activeChannel), 32'd2);

    // Reset mid-slot acts immediately.
    #1;
    reset = 1'b1;
    #1;
    chk("async.req",   32'(if_a.drawingRequest_out), 32'd0);
    chk("async.rgb",   32'(if_a.RGBout),             32'd0);
    chk("async.ch",    32'(if_a.activeChannel),      32'd0);
    chk("async.valid", 32'(if_a.slotValid),          32'd0);
    @(posedge clk); #1;
    reset = 1'b0;
    @(posedge clk); #1;
    chk("resume.ch",    32'(if_a.activeChannel), 32'd0);
    chk("resume.rgb",   32'(if_a.RGBout),        32'h10);
    chk("resume.valid", 32'(if_a.slotValid),     32'd1);

    // Mixed traffic, checked by the model every cycle.
    for (int i = 0; i < 32; i++) begin
      if_a.DrawingRequest_in = 4'((i * 5 + 3) % 16);
      if_a.mode              = ((i / 4) % 2) == 1;
      if_a.enableMask        = mix_mask[(i / 3) % 8];
      if_a.startOfFrame      = (i % 3) != 2;
      if_a.RGB_in            = {8'(8'h40 + i), 8'(8'h30 + i), 8'(8'h20 + i), 8'(8'h10 + i)};
      @(posedge clk); #1;
    end
    if_a.startOfFrame = 1'b0;
    repeat (2) @(posedge clk);
    #1;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
